// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control
//
// Multi-cycle control unit for a small RV32 subset (ADD, SUB, SRL, SRA and
// ADDI). Each instruction walks BOOT -> FETCH -> DECODE -> EXECUTE ->
// WRITEBACK. A fetch that is not acknowledged within TIMEOUT cycles parks
// the unit in HALT with a sticky bus error. Only rst leaves HALT.
//
// Parameters
//   RESET_PC        PC value loaded on reset
//   TIMEOUT         FETCH cycles without imem_ack before a bus error
//
// Ports
//   clk             clock, all state changes on the rising edge
//   rst             asynchronous reset, active-high
//   imem_req        instruction fetch request (high only in FETCH)
//   imem_ack        fetch acknowledge, imem_data valid in the same cycle
//   imem_data       fetched instruction word
//   pc              current instruction address
//   alu_instr_type  ALU instruction class (0 R, 1 I, 7 none)
//   alu_funct3      funct3 to the ALU
//   alu_funct7      funct7 to the ALU
//   alu_src_imm     ALU operand b select: 0 rs2, 1 imm
//   imm             sign-extended I-immediate (0 for R-type)
//   rs1, rs2, rd    register indices taken from the latched instruction
//   rf_we           register-file write enable (WRITEBACK, rd != 0)
//   illegal         one-cycle pulse after an unsupported instruction
//   bus_err         sticky fetch-timeout flag
//   retired         count of retired legal instructions
// ---------------------------------------------------------------------------
module mc_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [3:0]  alu_instr_type,
    output logic [2:0]  alu_funct3,
    output logic [6:0]  alu_funct7,
    output logic        alu_src_imm,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        rf_we,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] retired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [3:0] TYPE_R    = 4'd0;
    localparam logic [3:0] TYPE_I    = 4'd1;
    localparam logic [3:0] TYPE_NONE = 4'd7;

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      ir_q;
    logic [31:0]      retired_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             imem_req_q;
    logic             rf_we_q;
    logic             illegal_q;
    logic             bus_err_q;
    logic [3:0]       alu_type_q;
    logic [2:0]       alu_funct3_q;
    logic [6:0]       alu_funct7_q;
    logic             alu_src_imm_q;
    logic [31:0]      imm_q;

    // ------------------------------------------------------------------
    // Instruction decode of the latched word. These are the values the
    // ALU control registers take when DECODE completes.
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_r;
    logic        is_i;
    logic        legal_d;
    logic [3:0]  alu_type_d;
    logic [6:0]  alu_funct7_d;
    logic [31:0] imm_d;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];

    // R-type: ADD/SUB (funct3 000) and SRL/SRA (funct3 101), funct7 0 or 0x20.
    assign is_r = (opcode == OP_REG)
               && ((funct3 == 3'b000) || (funct3 == 3'b101))
               && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
    assign is_i = (opcode == OP_IMM) && (funct3 == 3'b000);
    assign legal_d = is_r || is_i;

    assign alu_type_d   = is_i ? TYPE_I : TYPE_R;
    // For I-type the upper bits belong to the immediate, so funct7 is zeroed.
    assign alu_funct7_d = is_r ? funct7 : 7'd0;
    assign imm_d        = is_i ? {{20{ir_q[31]}}, ir_q[31:20]} : 32'd0;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    // NOTE: all state is updated with non-blocking assignments so every
    // register samples values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            ir_q          <= 32'd0;
            retired_q     <= 32'd0;
            wait_cnt_q    <= '0;
            imem_req_q    <= 1'b0;
            rf_we_q       <= 1'b0;
            illegal_q     <= 1'b0;
            bus_err_q     <= 1'b0;
            alu_type_q    <= TYPE_NONE;
            alu_funct3_q  <= 3'd0;
            alu_funct7_q  <= 7'd0;
            alu_src_imm_q <= 1'b0;
            imm_q         <= 32'd0;
        end else begin
            // NOTE: default-clear here so the illegal pulse lasts exactly
            // one cycle; the DECODE branch below overrides it when needed.
            illegal_q <= 1'b0;

            case (state_q)
                S_BOOT: begin
                    state_q    <= S_FETCH;
                    imem_req_q <= 1'b1;
                    wait_cnt_q <= '0;
                end

                S_FETCH: begin
                    if (imem_ack) begin
                        ir_q       <= imem_data;
                        state_q    <= S_DECODE;
                        imem_req_q <= 1'b0;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        // This was the TIMEOUT-th cycle without an ack.
                        state_q    <= S_HALT;
                        imem_req_q <= 1'b0;
                        bus_err_q  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end

                S_DECODE: begin
                    if (legal_d) begin
                        state_q       <= S_EXECUTE;
                        alu_type_q    <= alu_type_d;
                        alu_funct3_q  <= funct3;
                        alu_funct7_q  <= alu_funct7_d;
                        alu_src_imm_q <= is_i;
                        imm_q         <= imm_d;
                    end else begin
                        // Skip the instruction without retiring it.
                        state_q    <= S_FETCH;
                        pc_q       <= pc_q + 32'd4;
                        illegal_q  <= 1'b1;
                        imem_req_q <= 1'b1;
                        wait_cnt_q <= '0;
                    end
                end

                S_EXECUTE: begin
                    state_q <= S_WRITEBACK;
                    rf_we_q <= (ir_q[11:7] != 5'd0);
                end

                S_WRITEBACK: begin
                    state_q       <= S_FETCH;
                    rf_we_q       <= 1'b0;
                    pc_q          <= pc_q + 32'd4;
                    retired_q     <= retired_q + 32'd1;
                    imem_req_q    <= 1'b1;
                    wait_cnt_q    <= '0;
                    alu_type_q    <= TYPE_NONE;
                    alu_funct3_q  <= 3'd0;
                    alu_funct7_q  <= 7'd0;
                    alu_src_imm_q <= 1'b0;
                    imm_q         <= 32'd0;
                end

                S_HALT: begin
                    // Terminal until reset; acks are ignored.
                    state_q <= S_HALT;
                end

                default: begin
                    state_q    <= S_HALT;
                    imem_req_q <= 1'b0;
                    rf_we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req       = imem_req_q;
    assign pc             = pc_q;
    assign alu_instr_type = alu_type_q;
    assign alu_funct3     = alu_funct3_q;
    assign alu_funct7     = alu_funct7_q;
    assign alu_src_imm    = alu_src_imm_q;
    assign imm            = imm_q;
    assign rs1            = ir_q[19:15];
    assign rs2            = ir_q[24:20];
    assign rd             = ir_q[11:7];
    assign rf_we          = rf_we_q;
    assign illegal        = illegal_q;
    assign bus_err        = bus_err_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// ---------------------------------------------------------------------------
// tb_mc_control
//
// Directed bench for mc_control. Inputs change just after the falling edge
// and outputs are sampled on the falling edge, half a cycle away from the
// rising edge where the DUT updates. Each test task starts and ends with the
// DUT in the first cycle of FETCH (except around reset).
// ---------------------------------------------------------------------------
module tb_mc_control;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [3:0]  alu_instr_type;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic        alu_src_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rf_we;
    logic        illegal;
    logic        bus_err;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    mc_control #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_ack       (imem_ack),
        .imem_data      (imem_data),
        .pc             (pc),
        .alu_instr_type (alu_instr_type),
        .alu_funct3     (alu_funct3),
        .alu_funct7     (alu_funct7),
        .alu_src_imm    (alu_src_imm),
        .imm            (imm),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd),
        .rf_we          (rf_we),
        .illegal        (illegal),
        .bus_err        (bus_err),
        .retired        (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bundles used for compact comparisons.
    logic [3:0]  flags;    // {imem_req, rf_we, illegal, bus_err}
    logic [14:0] alu_ctl;  // {type, funct3, funct7, src_imm}
    logic [14:0] regs;     // {rs1, rs2, rd}
    assign flags   = {imem_req, rf_we, illegal, bus_err};
    assign alu_ctl = {alu_instr_type, alu_funct3, alu_funct7, alu_src_imm};
    assign regs    = {rs1, rs2, rd};

    // ------------------------------------------------------------------
    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if (flags !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want %b", flags, 4'b0000);
        end
        total++;
        if (pc !== 32'h0 || retired !== 32'h0) begin
            bad++; $display("FAIL reset_pc_retired: got pc=%h ret=%h want 0/0", pc, retired);
        end
        total++;
        if (alu_ctl !== {4'd7, 3'd0, 7'd0, 1'b0} || imm !== 32'h0) begin
            bad++; $display("FAIL reset_alu: got ctl=%h imm=%h want %h/0", alu_ctl, imm, {4'd7, 11'd0});
        end
        total++;
        if (regs !== 15'd0) begin
            bad++; $display("FAIL reset_regs: got %h want 0", regs);
        end
        rst = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL boot_req: got %b want 0", imem_req);
        end
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || pc !== 32'h0) begin
            bad++; $display("FAIL first_fetch: got req=%b pc=%h want 1/0", imem_req, pc);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_add;
        imem_ack  = 1'b1;
        imem_data = 32'h0020_81B3;              // add x3, x1, x2
        @(negedge clk);                         // DECODE
        // An ack outside FETCH must not disturb the latched instruction.
        imem_data = 32'hFFFF_FFFF;
        total++;
        if (imem_req !== 1'b0 || regs !== {5'd1, 5'd2, 5'd3}) begin
            bad++; $display("FAIL add_decode: got req=%b regs=%h want 0/%h", imem_req, regs, {5'd1, 5'd2, 5'd3});
        end
        total++;
        if (alu_instr_type !== 4'd7) begin
            bad++; $display("FAIL add_decode_type: got %0d want 7", alu_instr_type);
        end
        @(negedge clk);                         // EXECUTE
        imem_ack = 1'b0;
        total++;
        if (alu_ctl !== {4'd0, 3'd0, 7'd0, 1'b0} || imm !== 32'h0 || rd !== 5'd3) begin
            bad++; $display("FAIL add_execute: got ctl=%h imm=%h rd=%0d want 0/0/3", alu_ctl, imm, rd);
        end
        total++;
        if (rf_we !== 1'b0) begin
            bad++; $display("FAIL add_execute_we: got %b want 0", rf_we);
        end
        @(negedge clk);                         // WRITEBACK
        total++;
        if (rf_we !== 1'b1 || alu_ctl !== {4'd0, 3'd0, 7'd0, 1'b0} || pc !== 32'h0) begin
            bad++; $display("FAIL add_writeback: got we=%b ctl=%h pc=%h want 1/0/0", rf_we, alu_ctl, pc);
        end
        @(negedge clk);                         // FETCH, 4 cycles after first req
        total++;
        if (imem_req !== 1'b1 || pc !== 32'h4 || retired !== 32'd1) begin
            bad++; $display("FAIL add_next_fetch: got req=%b pc=%h ret=%0d want 1/4/1", imem_req, pc, retired);
        end
        total++;
        if (rf_we !== 1'b0 || alu_instr_type !== 4'd7) begin
            bad++; $display("FAIL add_after: got we=%b type=%0d want 0/7", rf_we, alu_instr_type);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_addi;
        // Ack held off for three cycles; req must stay up throughout.
        repeat (3) begin
            @(negedge clk);
            total++;
            if (imem_req !== 1'b1) begin
                bad++; $display("FAIL addi_wait_req: got %b want 1", imem_req);
            end
        end
        imem_ack  = 1'b1;
        imem_data = 32'hFFF0_0293;              // addi x5, x0, -1
        @(negedge clk);                         // DECODE
        imem_ack = 1'b0;
        @(negedge clk);                         // EXECUTE
        total++;
        if (alu_instr_type !== 4'd1 || alu_funct3 !== 3'd0 || alu_src_imm !== 1'b1) begin
            bad++; $display("FAIL addi_execute: got type=%0d f3=%0d src=%b want 1/0/1", alu_instr_type, alu_funct3, alu_src_imm);
        end
        total++;
        if (imm !== 32'hFFFF_FFFF || rd !== 5'd5) begin
            bad++; $display("FAIL addi_imm: got imm=%h rd=%0d want ffffffff/5", imm, rd);
        end
        @(negedge clk);                         // WRITEBACK
        total++;
        if (rf_we !== 1'b1 || imem_req !== 1'b0) begin
            bad++; $display("FAIL addi_writeback: got we=%b req=%b want 1/0", rf_we, imem_req);
        end
        @(negedge clk);                         // FETCH, 7 cycles after first req
        total++;
        if (imem_req !== 1'b1 || pc !== 32'h8 || retired !== 32'd2) begin
            bad++; $display("FAIL addi_next_fetch: got req=%b pc=%h ret=%0d want 1/8/2", imem_req, pc, retired);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_sra_nop;
        imem_ack  = 1'b1;
        imem_data = 32'h4031_50B3;              // sra x1, x2, x3
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);                         // EXECUTE
        total++;
        if (alu_ctl !== {4'd0, 3'b101, 7'b0100000, 1'b0} || imm !== 32'h0) begin
            bad++; $display("FAIL sra_execute: got ctl=%h imm=%h want %h/0", alu_ctl, imm, {4'd0, 3'b101, 7'b0100000, 1'b0});
        end
        total++;
        if (regs !== {5'd2, 5'd3, 5'd1}) begin
            bad++; $display("FAIL sra_regs: got %h want %h", regs, {5'd2, 5'd3, 5'd1});
        end
        @(negedge clk);                         // WRITEBACK
        total++;
        if (rf_we !== 1'b1) begin
            bad++; $display("FAIL sra_writeback: got %b want 1", rf_we);
        end
        @(negedge clk);
        total++;
        if (pc !== 32'hC || retired !== 32'd3) begin
            bad++; $display("FAIL sra_retire: got pc=%h ret=%0d want c/3", pc, retired);
        end

        imem_ack  = 1'b1;
        imem_data = 32'h0000_0013;              // nop (addi x0, x0, 0)
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);                         // EXECUTE
        total++;
        if (alu_instr_type !== 4'd1 || alu_src_imm !== 1'b1 || imm !== 32'h0) begin
            bad++; $display("FAIL nop_execute: got type=%0d src=%b imm=%h want 1/1/0", alu_instr_type, alu_src_imm, imm);
        end
        @(negedge clk);                         // WRITEBACK with rd = 0
        total++;
        if (rf_we !== 1'b0) begin
            bad++; $display("FAIL nop_writeback: got we=%b want 0", rf_we);
        end
        @(negedge clk);
        total++;
        if (pc !== 32'h10 || retired !== 32'd4 || imem_req !== 1'b1) begin
            bad++; $display("FAIL nop_retire: got pc=%h ret=%0d req=%b want 10/4/1", pc, retired, imem_req);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_illegal;
        imem_ack  = 1'b1;
        imem_data = 32'h0000_1033;              // sll: not supported
        @(negedge clk);                         // DECODE
        imem_ack = 1'b0;
        total++;
        if (illegal !== 1'b0 || rf_we !== 1'b0) begin
            bad++; $display("FAIL illegal_decode: got ill=%b we=%b want 0/0", illegal, rf_we);
        end
        @(negedge clk);                         // back in FETCH
        total++;
        if (illegal !== 1'b1 || rf_we !== 1'b0 || imem_req !== 1'b1) begin
            bad++; $display("FAIL illegal_pulse: got ill=%b we=%b req=%b want 1/0/1", illegal, rf_we, imem_req);
        end
        total++;
        if (pc !== 32'h14 || retired !== 32'd4 || alu_instr_type !== 4'd7) begin
            bad++; $display("FAIL illegal_pc: got pc=%h ret=%0d type=%0d want 14/4/7", pc, retired, alu_instr_type);
        end
        imem_ack  = 1'b1;
        imem_data = 32'h0020_81B3;              // add x3, x1, x2
        @(negedge clk);                         // DECODE
        imem_ack = 1'b0;
        total++;
        if (illegal !== 1'b0) begin
            bad++; $display("FAIL illegal_width: got %b want 0", illegal);
        end
        repeat (3) @(negedge clk);
        total++;
        if (pc !== 32'h18 || retired !== 32'd5) begin
            bad++; $display("FAIL illegal_recover: got pc=%h ret=%0d want 18/5", pc, retired);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout;
        imem_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (imem_req !== 1'b1 || bus_err !== 1'b0) begin
                bad++; $display("FAIL timeout_wait%0d: got req=%b err=%b want 1/0", i, imem_req, bus_err);
            end
            @(negedge clk);
        end
        total++;
        if (bus_err !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h18) begin
            bad++; $display("FAIL timeout_halt: got err=%b req=%b pc=%h want 1/0/18", bus_err, imem_req, pc);
        end
        // Acks in HALT are ignored.
        imem_ack  = 1'b1;
        imem_data = 32'h0020_81B3;
        repeat (3) @(negedge clk);
        total++;
        if (flags !== 4'b0001 || pc !== 32'h18 || retired !== 32'd5 || alu_instr_type !== 4'd7) begin
            bad++; $display("FAIL halt_frozen: got flags=%b pc=%h ret=%0d type=%0d want 0001/18/5/7", flags, pc, retired, alu_instr_type);
        end
        imem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus_err !== 1'b0 || pc !== 32'h0 || retired !== 32'd0) begin
            bad++; $display("FAIL halt_reset: got err=%b pc=%h ret=%0d want 0/0/0", bus_err, pc, retired);
        end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_execute;
        rst = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL rx_boot: got req=%b want 0", imem_req);
        end
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1) begin
            bad++; $display("FAIL rx_fetch: got req=%b want 1", imem_req);
        end
        imem_ack  = 1'b1;
        imem_data = 32'h0020_81B3;
        @(negedge clk);                         // DECODE
        imem_ack = 1'b0;
        @(negedge clk);                         // EXECUTE
        total++;
        if (alu_instr_type !== 4'd0) begin
            bad++; $display("FAIL rx_execute: got type=%0d want 0", alu_instr_type);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (flags !== 4'b0000 || pc !== 32'h0 || retired !== 32'd0) begin
            bad++; $display("FAIL rx_async: got flags=%b pc=%h ret=%0d want 0000/0/0", flags, pc, retired);
        end
        total++;
        if (alu_ctl !== {4'd7, 11'd0} || imm !== 32'h0 || regs !== 15'd0) begin
            bad++; $display("FAIL rx_async_alu: got ctl=%h imm=%h regs=%h want %h/0/0", alu_ctl, imm, regs, {4'd7, 11'd0});
        end
        repeat (2) begin
            @(negedge clk);
            total++;
            if (rf_we !== 1'b0 || imem_req !== 1'b0) begin
                bad++; $display("FAIL rx_hold: got we=%b req=%b want 0/0", rf_we, imem_req);
            end
        end
        rst = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL rx_boot2: got req=%b want 0", imem_req);
        end
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || pc !== 32'h0 || retired !== 32'd0) begin
            bad++; $display("FAIL rx_fetch2: got req=%b pc=%h ret=%0d want 1/0/0", imem_req, pc, retired);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        imem_ack  = 1'b0;
        imem_data = 32'h0;
        test_reset;
        test_add;
        test_addi;
        test_sra_nop;
        test_illegal;
        test_timeout;
        test_reset_execute;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
